// File: rtl/pipe_seq_ctrl_pkg.sv
// Pipeline sequencer shared definitions.
// State codes and the control-output bundle used by pipe_seq_ctrl.
package pipe_seq_ctrl_pkg;

    localparam int DEF_FILL_CYCLES  = 3;
    localparam int DEF_DRAIN_CYCLES = 3;
    localparam int DEF_MAX_STALL    = 7;
    localparam int DEF_CNT_W        = 3;

    localparam logic [2:0] ST_FILL  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STALL = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_flush;
        logic wb_en;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        pc_we: 1'b0, ifid_we: 1'b0,
        ifid_flush: 1'b1, idex_bubble: 1'b1,
        exmem_flush: 1'b1, wb_en: 1'b0,
        halted: 1'b0
    };

    localparam ctrl_t CTRL_FILL = '{
        pc_we: 1'b1, ifid_we: 1'b1,
        ifid_flush: 1'b0, idex_bubble: 1'b1,
        exmem_flush: 1'b0, wb_en: 1'b0,
        halted: 1'b0
    };

    localparam ctrl_t CTRL_RUN = '{
        pc_we: 1'b1, ifid_we: 1'b1,
        ifid_flush: 1'b0, idex_bubble: 1'b0,
        exmem_flush: 1'b0, wb_en: 1'b1,
        halted: 1'b0
    };

    // Squash the wrong-path fetch while PC loads the branch target.
    localparam ctrl_t CTRL_BRANCH = '{
        pc_we: 1'b1, ifid_we: 1'b1,
        ifid_flush: 1'b1, idex_bubble: 1'b1,
        exmem_flush: 1'b1, wb_en: 1'b1,
        halted: 1'b0
    };

    localparam ctrl_t CTRL_HOLD = '{
        pc_we: 1'b0, ifid_we: 1'b0,
        ifid_flush: 1'b0, idex_bubble: 1'b1,
        exmem_flush: 1'b0, wb_en: 1'b1,
        halted: 1'b0
    };

    localparam ctrl_t CTRL_HALT = '{
        pc_we: 1'b0, ifid_we: 1'b0,
        ifid_flush: 1'b0, idex_bubble: 1'b1,
        exmem_flush: 1'b0, wb_en: 1'b0,
        halted: 1'b1
    };

endpackage

// File: rtl/pipe_seq_ctrl_sat_counter.sv
// Saturating up-counter with async reset and synchronous clear.
// A clear with inc set loads 1, so a new run can start counting at once.
module sat_counter #(
    parameter int W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && count != MAX) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer: fill, run, stall, flush, drain-to-halt,
// plus a sticky stall watchdog.
module pipe_seq_ctrl #(
    parameter int FILL_CYCLES  = 3,
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_STALL    = 7,
    parameter int CNT_W        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             halt_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             wb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             stall_err
);

    import pipe_seq_ctrl_pkg::*;

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    ctrl_t            ctrl;
    ctrl_t            outs;
    logic             fill_inc;
    logic             drain_inc;
    logic             stall_inc;
    logic             err_q;
    logic             at_max;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] drain_cnt;

    sat_counter #(.W(CNT_W)) u_fill (
        .clock (clock),
        .reset (reset),
        .clr   (~fill_inc),
        .inc   (fill_inc),
        .count (fill_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drain (
        .clock (clock),
        .reset (reset),
        .clr   (~drain_inc),
        .inc   (drain_inc),
        .count (drain_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall (
        .clock (clock),
        .reset (reset),
        .clr   (~stall_inc),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    always_comb begin
        ctrl      = CTRL_FILL;
        state_d   = state_q;
        fill_inc  = 1'b0;
        drain_inc = 1'b0;
        stall_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                ctrl = CTRL_RUN;
                if (branch_taken) begin
                    ctrl    = CTRL_BRANCH;
                    state_d = ST_FLUSH;
                end else if (hazard_stall) begin
                    ctrl      = CTRL_HOLD;
                    stall_inc = 1'b1;
                    state_d   = ST_STALL;
                end else if (halt_req) begin
                    ctrl    = CTRL_HOLD;
                    state_d = ST_DRAIN;
                end
            end
            ST_STALL: begin
                if (branch_taken) begin
                    ctrl    = CTRL_BRANCH;
                    state_d = ST_FLUSH;
                end else if (hazard_stall) begin
                    ctrl      = CTRL_HOLD;
                    stall_inc = 1'b1;
                end else begin
                    ctrl    = CTRL_RUN;
                    state_d = ST_RUN;
                end
            end
            // Stall here came from squashed instructions.
            ST_FLUSH: begin
                if (branch_taken) begin
                    ctrl = CTRL_BRANCH;
                end else begin
                    ctrl    = CTRL_RUN;
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                ctrl      = CTRL_HOLD;
                drain_inc = 1'b1;
                if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1))
                    state_d = ST_HALT;
            end
            ST_HALT: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                fill_inc = 1'b1;
                if (fill_cnt == CNT_W'(FILL_CYCLES - 1))
                    state_d = ST_RUN;
                else
                    state_d = ST_FILL;
            end
        endcase
    end

    assign at_max = (stall_cnt == CNT_W'(MAX_STALL));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (at_max)
                err_q <= 1'b1;
        end
    end

    assign outs        = reset ? CTRL_RESET : ctrl;
    assign pc_we       = outs.pc_we;
    assign ifid_we     = outs.ifid_we;
    assign ifid_flush  = outs.ifid_flush;
    assign idex_bubble = outs.idex_bubble;
    assign exmem_flush = outs.exmem_flush;
    assign wb_en       = outs.wb_en;
    assign halted      = outs.halted;
    assign stall_err   = ~reset & (err_q | at_max);

endmodule
